// File: rtl/sorted_list_k.sv
// sorted_list_k: keeps the K smallest L2 distances with their merged indices, ascending, one insert per clock.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   restart                    discard the current list and start a new query
//   insert, last_in            present a candidate; last_in marks the final candidate of a query
//   l2_dist_in, merged_idx_in  candidate distance and index
//   valid_out                  one-cycle pulse after the final candidate of a query has been taken
//   l2_dist_flat               entry i at [i*DIST_WIDTH +: DIST_WIDTH], entry 0 smallest
//   merged_idx_flat            entry i at [i*IDX_WIDTH +: IDX_WIDTH]
//   entry_valid, count         per-entry valid bits and number of valid entries
//   worst_dist                 distance of entry K-1 when the list is full, else all-ones
module sorted_list_k #(
    parameter int K          = 4,
    parameter int DIST_WIDTH = 25,
    parameter int IDX_WIDTH  = 15,
    parameter int DEDUP      = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      restart,
    input  logic                      insert,
    input  logic                      last_in,
    input  logic [DIST_WIDTH-1:0]     l2_dist_in,
    input  logic [IDX_WIDTH-1:0]      merged_idx_in,
    output logic                      valid_out,
    output logic [K*DIST_WIDTH-1:0]   l2_dist_flat,
    output logic [K*IDX_WIDTH-1:0]    merged_idx_flat,
    output logic [K-1:0]              entry_valid,
    output logic [$clog2(K+1)-1:0]    count,
    output logic [DIST_WIDTH-1:0]     worst_dist
);
    localparam int CW = $clog2(K+1);
    logic [DIST_WIDTH-1:0] dist_q [K];
    logic [DIST_WIDTH-1:0] dist_d [K];
    logic [DIST_WIDTH-1:0] bdist  [K];
    logic [IDX_WIDTH-1:0]  idx_q  [K];
    logic [IDX_WIDTH-1:0]  idx_d  [K];
    logic [IDX_WIDTH-1:0]  bidx   [K];
    logic [K-1:0]          vld_q, vld_d, bvld;
    logic [CW-1:0]         cnt_q, cnt_d, bcnt;
    logic                  vout_q, vout_d;
    logic                  has_m, drop;
    int                    p, mj, last;

    // A restart makes the old contents invisible, so the insert works on a reset-valued base list.
    always_comb begin
        bvld = restart ? '0 : vld_q;
        bcnt = restart ? '0 : cnt_q;
        for (int i = 0; i < K; i++) begin
            bdist[i] = restart ? '1 : dist_q[i];
            bidx[i]  = restart ? '0 : idx_q[i];
        end
        p     = K;
        mj    = 0;
        has_m = 1'b0;
        for (int i = K-1; i >= 0; i--) begin
            if (!bvld[i] || l2_dist_in <= bdist[i]) p = i;
            if (DEDUP != 0 && bvld[i] && bidx[i] == merged_idx_in) begin
                has_m = 1'b1;
                mj    = i;
            end
        end
        // A matching index bounds the shift at the match slot; otherwise the tail entry falls off.
        drop = has_m ? (bdist[mj] <= l2_dist_in) : (p == K);
        last = has_m ? mj : K-1;
        for (int i = 0; i < K; i++) begin
            dist_d[i] = bdist[i];
            idx_d[i]  = bidx[i];
            vld_d[i]  = bvld[i];
            if (insert && !drop) begin
                if (i == p) begin
                    dist_d[i] = l2_dist_in;
                    idx_d[i]  = merged_idx_in;
                    vld_d[i]  = 1'b1;
                end else if (i > p && i <= last) begin
                    dist_d[i] = bdist[(i > 0) ? i-1 : 0];
                    idx_d[i]  = bidx[(i > 0) ? i-1 : 0];
                    vld_d[i]  = bvld[(i > 0) ? i-1 : 0];
                end
            end
        end
        cnt_d  = (insert && !drop && !has_m && bcnt != CW'(K)) ? bcnt + 1'b1 : bcnt;
        vout_d = insert && last_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= '1;
                idx_q[i]  <= '0;
            end
            vld_q  <= '0;
            cnt_q  <= '0;
            vout_q <= 1'b0;
        end else begin
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= dist_d[i];
                idx_q[i]  <= idx_d[i];
            end
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            vout_q <= vout_d;
        end
    end

    for (genvar g = 0; g < K; g++) begin : g_flat
        assign l2_dist_flat[g*DIST_WIDTH +: DIST_WIDTH] = dist_q[g];
        assign merged_idx_flat[g*IDX_WIDTH +: IDX_WIDTH] = idx_q[g];
    end

    assign valid_out   = vout_q;
    assign entry_valid = vld_q;
    assign count       = cnt_q;
    assign worst_dist  = (cnt_q == CW'(K)) ? dist_q[K-1] : '1;
endmodule

// File: tb/tb_sorted_list_k.sv
// tb_sorted_list_k: directed checks of sorted_list_k at K=4/DEDUP=0 and K=8/DEDUP=1.
module tb_sorted_list_k;
    localparam logic [24:0] ONES = 25'h1FF_FFFF;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        restart = 1'b0, insert = 1'b0, last_in = 1'b0;
    logic [24:0] l2_dist_in = '0;
    logic [14:0] merged_idx_in = '0;
    logic        vo4, vo8;
    logic [99:0] dist4;
    logic [59:0] idx4;
    logic [3:0]  ev4;
    logic [2:0]  cnt4;
    logic [24:0] wd4, wd8;
    logic [199:0] dist8;
    logic [119:0] idx8;
    logic [7:0]  ev8;
    logic [3:0]  cnt8;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    sorted_list_k #(.K(4), .DIST_WIDTH(25), .IDX_WIDTH(15), .DEDUP(0)) u4 (
        .clk(clk), .rst_n(rst_n), .restart(restart), .insert(insert), .last_in(last_in),
        .l2_dist_in(l2_dist_in), .merged_idx_in(merged_idx_in), .valid_out(vo4),
        .l2_dist_flat(dist4), .merged_idx_flat(idx4), .entry_valid(ev4), .count(cnt4), .worst_dist(wd4));

    sorted_list_k #(.K(8), .DIST_WIDTH(25), .IDX_WIDTH(15), .DEDUP(1)) u8 (
        .clk(clk), .rst_n(rst_n), .restart(restart), .insert(insert), .last_in(last_in),
        .l2_dist_in(l2_dist_in), .merged_idx_in(merged_idx_in), .valid_out(vo8),
        .l2_dist_flat(dist8), .merged_idx_flat(idx8), .entry_valid(ev8), .count(cnt8), .worst_dist(wd8));

    function automatic logic [24:0] d4(int i); return dist4[i*25 +: 25]; endfunction
    function automatic logic [14:0] i4(int i); return idx4[i*15 +: 15]; endfunction
    function automatic logic [24:0] d8(int i); return dist8[i*25 +: 25]; endfunction
    function automatic logic [14:0] i8(int i); return idx8[i*15 +: 15]; endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op(input logic r, input logic ins, input logic lst, input logic [24:0] d, input logic [14:0] ix);
        @(negedge clk);
        restart = r; insert = ins; last_in = lst; l2_dist_in = d; merged_idx_in = ix;
        @(posedge clk);
        #1;
        restart = 1'b0; insert = 1'b0; last_in = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_cnt", cnt4, 0);
        chk("rst_ev", ev4, 0);
        chk("rst_vo", vo4, 0);
        chk("rst_wd", wd4, ONES);
        chk("rst_dist", dist4, {100{1'b1}});
        chk("rst_idx", idx4, 0);
        @(negedge clk); rst_n = 1'b1;

        // basic ordering with ties newest-first
        op(1, 1, 0, 2046, 0);
        chk("t1_d0", d4(0), 2046); chk("t1_cnt1", cnt4, 1);
        op(0, 1, 0, 3, 15'd512);
        chk("t1_d0b", d4(0), 3); chk("t1_d1b", d4(1), 2046);
        op(0, 1, 0, 2046, 15'd1024);
        chk("t1_ix", {i4(0), i4(1), i4(2)}, {15'd512, 15'd1024, 15'd0});
        op(0, 1, 0, 2047, 15'd1536);
        op(0, 1, 0, 2, 0);
        op(0, 1, 0, 2, 15'd2560);
        chk("t1_dists", {d4(0), d4(1), d4(2), d4(3)}, {25'd2, 25'd2, 25'd3, 25'd2046});
        chk("t1_idxs", {i4(0), i4(1), i4(2), i4(3)}, {15'd2560, 15'd0, 15'd512, 15'd1024});
        chk("t1_wd", wd4, 2046);
        chk("t1_cnt", cnt4, 4);
        chk("t1_vo", vo4, 0);

        // full list: strict-greater drop, then final insert with valid_out pulse
        op(1, 1, 0, 1, 1); op(0, 1, 0, 2, 2); op(0, 1, 0, 3, 3); op(0, 1, 0, 2046, 4);
        op(0, 1, 0, 3000, 5);
        chk("t2_drop", {d4(0), d4(1), d4(2), d4(3)}, {25'd1, 25'd2, 25'd3, 25'd2046});
        chk("t2_cnt", cnt4, 4);
        op(0, 1, 1, 0, 6);
        chk("t2_list", {d4(0), d4(1), d4(2), d4(3)}, {25'd0, 25'd1, 25'd2, 25'd3});
        chk("t2_vo_hi", vo4, 1);
        chk("t2_wd", wd4, 3);
        @(posedge clk); #1;
        chk("t2_vo_lo", vo4, 0);
        op(0, 0, 1, 0, 0);
        @(posedge clk); #1;
        chk("t2_last_noins", vo4, 0);

        // restart mid-query
        op(1, 1, 0, 20, 15'd3072);
        chk("t3_d0", d4(0), 20); chk("t3_cnt", cnt4, 1);
        chk("t3_ev", ev4, 4'b0001); chk("t3_wd", wd4, ONES);
        chk("t3_tail", {d4(1), d4(2), d4(3)}, {75{1'b1}});
        op(1, 0, 0, 0, 0);
        chk("t3_clr_cnt", cnt4, 0); chk("t3_clr_dist", dist4, {100{1'b1}});
        op(1, 1, 1, 9, 9);
        chk("t3_rl_vo", vo4, 1); chk("t3_rl_cnt", cnt4, 1);

        // index dedup on the K=8 instance; duplicates kept on the K=4 one
        op(1, 1, 0, 10, 7);
        op(0, 1, 0, 12, 7);
        chk("t4_dup_drop", cnt8, 1);
        chk("t4_dup_keep4", cnt4, 2);
        op(0, 1, 0, 4, 3);
        op(0, 1, 0, 15, 9);
        chk("t4_pre", {d8(0), i8(0), d8(1), i8(1), d8(2), i8(2)},
            {25'd4, 15'd3, 25'd10, 15'd7, 25'd15, 15'd9});
        op(0, 1, 0, 4, 7);
        chk("t4_list", {d8(0), i8(0), d8(1), i8(1), d8(2), i8(2)},
            {25'd4, 15'd7, 25'd4, 15'd3, 25'd15, 15'd9});
        chk("t4_cnt", cnt8, 3);
        chk("t4_ev", ev8, 8'b0000_0111);
        chk("t4_wd8", wd8, ONES);

        // all-ones distance into an empty slot is a real entry
        op(1, 1, 0, ONES, 0);
        chk("t5_ev", ev4, 4'b0001); chk("t5_cnt", cnt4, 1);
        op(0, 1, 0, 5, 1); op(0, 1, 0, 6, 2); op(0, 1, 0, 7, 3);
        chk("t5_full_cnt", cnt4, 4);
        chk("t5_wd_ones", wd4, ONES);
        op(0, 1, 0, 8, 4);
        chk("t5_wd", wd4, 8);
        chk("t5_d3", d4(3), 8);

        // asynchronous reset right after a last_in insert
        op(0, 1, 1, 1, 1);
        chk("t6_vo_pre", vo4, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_vo_async", vo4, 0);
        chk("t6_cnt_async", cnt4, 0);
        chk("t6_dist_async", dist4, {100{1'b1}});
        @(posedge clk); #1;
        chk("t6_vo_hold", vo4, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_vo_after", vo4, 0);
        chk("t6_cnt_after", cnt4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
